regfile_wb_sched: RTL and testbench

REGFILE_WB_SCHED -- requirements
Module: regfile_wb_sched

---
 rtl/regfile_ctrl_pkg.sv | 16 +
 rtl/regfile_wb_sched_rr_arb2.sv | 36 +++
 rtl/regfile_wb_sched.sv | 117 +++++++++++
 tb/tb_regfile_wb_sched.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared defaults and the writeback request record for the register-file
// writeback scheduler.
package regfile_ctrl_pkg;

  localparam int NUM_REG_DEF   = 8;
  localparam int SEL_WIDTH_DEF = 3;
  localparam int D_WIDTH_DEF   = 34;

  // One writeback: destination select plus data, tagged with a valid bit.
  typedef struct packed {
    logic                     valid;
    logic [SEL_WIDTH_DEF-1:0] sel;
    logic [D_WIDTH_DEF-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer favours the requester that lost
// the most recent transfer.
module rr_arb2 (
  input  logic clk,
  input  logic reset_i,
  input  logic req0_valid_i,
  input  logic req1_valid_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  logic ptr_q;

  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (!reset_i) begin
      if (req0_valid_i && (!req1_valid_i || !ptr_q)) begin
        gnt0_o = 1'b1;
      end else if (req1_valid_i) begin
        gnt1_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      ptr_q <= 1'b0;
    end else if (gnt0_o) begin
      ptr_q <= 1'b1;
    end else if (gnt1_o) begin
      ptr_q <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler: arbitrates ALU/memory writebacks onto one register-file
// write port and tracks pending destination registers for decode hazards.
module regfile_wb_sched
  import regfile_ctrl_pkg::*;
#(
  parameter int NUM_REG   = NUM_REG_DEF,
  parameter int SEL_WIDTH = SEL_WIDTH_DEF,
  parameter int D_WIDTH   = D_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset_i,
  input  logic                 req0_valid_i,
  input  logic [SEL_WIDTH-1:0] req0_reg_i,
  input  logic [D_WIDTH-1:0]   req0_data_i,
  output logic                 req0_ready_o,
  input  logic                 req1_valid_i,
  input  logic [SEL_WIDTH-1:0] req1_reg_i,
  input  logic [D_WIDTH-1:0]   req1_data_i,
  output logic                 req1_ready_o,
  input  logic                 reserve_i,
  input  logic [SEL_WIDTH-1:0] reserve_reg_i,
  input  logic [SEL_WIDTH-1:0] rs_sel_i,
  input  logic [SEL_WIDTH-1:0] rt_sel_i,
  input  logic [SEL_WIDTH-1:0] rd_sel_i,
  output logic                 stall_o,
  output logic                 write_enable_o,
  output logic [SEL_WIDTH-1:0] write_reg_o,
  output logic [D_WIDTH-1:0]   write_data_o,
  output logic [NUM_REG-1:0]   busy_o,
  output logic                 err_o
);

  logic               gnt0;
  logic               gnt1;
  wb_req_t            req_p0;
  wb_req_t            wb_p1;
  logic [NUM_REG-1:0] busy_q;
  logic [NUM_REG-1:0] busy_d;
  logic               err_q;
  logic               err_d;

  rr_arb2 u_arb (
    .clk          (clk),
    .reset_i      (reset_i),
    .req0_valid_i (req0_valid_i),
    .req1_valid_i (req1_valid_i),
    .gnt0_o       (gnt0),
    .gnt1_o       (gnt1)
  );

  assign req0_ready_o = gnt0;
  assign req1_ready_o = gnt1;

  // Stage p0: select the granted request
  always_comb begin
    req_p0 = '0;
    if (gnt0) begin
      req_p0.valid = 1'b1;
      req_p0.sel   = req0_reg_i;
      req_p0.data  = req0_data_i;
    end else if (gnt1) begin
      req_p0.valid = 1'b1;
      req_p0.sel   = req1_reg_i;
      req_p0.data  = req1_data_i;
    end
  end

  // Stage p1: registered write port; address/data hold when idle
  always_ff @(posedge clk) begin
    if (reset_i) begin
      wb_p1 <= '0;
    end else begin
      wb_p1.valid <= req_p0.valid;
      if (req_p0.valid) begin
        wb_p1.sel  <= req_p0.sel;
        wb_p1.data <= req_p0.data;
      end
    end
  end

  // A reserve landing on the register being committed re-arms it, so the
  // set is applied after the clear.
  always_comb begin
    busy_d = busy_q;
    err_d  = err_q;
    if (wb_p1.valid) begin
      busy_d[wb_p1.sel] = 1'b0;
      if (!busy_q[wb_p1.sel]) begin
        err_d = 1'b1;
      end
    end
    if (reserve_i) begin
      busy_d[reserve_reg_i] = 1'b1;
      if (busy_q[reserve_reg_i] && !(wb_p1.valid && (wb_p1.sel == reserve_reg_i))) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign stall_o        = busy_q[rs_sel_i] | busy_q[rt_sel_i] | busy_q[rd_sel_i];
  assign write_enable_o = wb_p1.valid;
  assign write_reg_o    = wb_p1.sel;
  assign write_data_o   = wb_p1.data;
  assign busy_o         = busy_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Self-checking bench for regfile_wb_sched: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_regfile_wb_sched;

  localparam int NR = 8;
  localparam int SW = 3;
  localparam int DW = 34;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          req0_valid_i;
  logic [SW-1:0] req0_reg_i;
  logic [DW-1:0] req0_data_i;
  logic          req0_ready_o;
  logic          req1_valid_i;
  logic [SW-1:0] req1_reg_i;
  logic [DW-1:0] req1_data_i;
  logic          req1_ready_o;
  logic          reserve_i;
  logic [SW-1:0] reserve_reg_i;
  logic [SW-1:0] rs_sel_i;
  logic [SW-1:0] rt_sel_i;
  logic [SW-1:0] rd_sel_i;
  logic          stall_o;
  logic          write_enable_o;
  logic [SW-1:0] write_reg_o;
  logic [DW-1:0] write_data_o;
  logic [NR-1:0] busy_o;
  logic          err_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_wb_sched #(.NUM_REG(NR), .SEL_WIDTH(SW), .D_WIDTH(DW)) dut (
    .clk            (clk),
    .reset_i        (reset_i),
    .req0_valid_i   (req0_valid_i),
    .req0_reg_i     (req0_reg_i),
    .req0_data_i    (req0_data_i),
    .req0_ready_o   (req0_ready_o),
    .req1_valid_i   (req1_valid_i),
    .req1_reg_i     (req1_reg_i),
    .req1_data_i    (req1_data_i),
    .req1_ready_o   (req1_ready_o),
    .reserve_i      (reserve_i),
    .reserve_reg_i  (reserve_reg_i),
    .rs_sel_i       (rs_sel_i),
    .rt_sel_i       (rt_sel_i),
    .rd_sel_i       (rd_sel_i),
    .stall_o        (stall_o),
    .write_enable_o (write_enable_o),
    .write_reg_o    (write_reg_o),
    .write_data_o   (write_data_o),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  typedef struct {
    bit            rst;
    bit            v0;
    logic [SW-1:0] r0;
    logic [DW-1:0] d0;
    bit            v1;
    logic [SW-1:0] r1;
    logic [DW-1:0] d1;
    bit            res;
    logic [SW-1:0] rreg;
    logic [SW-1:0] rs;
    bit            e_r0;
    bit            e_r1;
    bit            e_stall;
    bit            e_we;
    logic [SW-1:0] e_wreg;
    logic [DW-1:0] e_wdata;
    logic [NR-1:0] e_busy;
    bit            e_err;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(
    input bit rst, input bit v0, input logic [SW-1:0] r0, input logic [DW-1:0] d0,
    input bit v1, input logic [SW-1:0] r1, input logic [DW-1:0] d1,
    input bit res, input logic [SW-1:0] rreg, input logic [SW-1:0] rs,
    input bit e_r0, input bit e_r1, input bit e_stall, input bit e_we,
    input logic [SW-1:0] e_wreg, input logic [DW-1:0] e_wdata,
    input logic [NR-1:0] e_busy, input bit e_err);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.r0 = r0; v.d0 = d0; v.v1 = v1; v.r1 = r1; v.d1 = d1;
    v.res = res; v.rreg = rreg; v.rs = rs;
    v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_stall = e_stall; v.e_we = e_we;
    v.e_wreg = e_wreg; v.e_wdata = e_wdata; v.e_busy = e_busy; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req0_valid_i  = 1'b0;
    req0_reg_i    = '0;
    req0_data_i   = '0;
    req1_valid_i  = 1'b0;
    req1_reg_i    = '0;
    req1_data_i   = '0;
    reserve_i     = 1'b0;
    reserve_reg_i = '0;
    rs_sel_i      = '0;
    rt_sel_i      = '0;
    rd_sel_i      = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_i = 1'b1;
    cyc();
    cyc();
    reset_i = 1'b0;
  endtask

  // Behavioural model state
  bit            m_ptr;
  bit            m_we;
  logic [SW-1:0] m_wreg;
  logic [DW-1:0] m_wdata;
  logic [NR-1:0] m_busy;
  bit            m_err;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] A, B, C, D, E, F;
    logic [63:0]   rnd;
    int            win;
    logic [NR-1:0] nb;

    A = 34'h1_2345_6789;
    B = 34'h2_0000_0004;
    C = 34'h3_FFFF_0005;
    D = 34'h0_DEAD_BEEF;
    E = 34'h1_CAFE_0007;
    F = 34'h2_F00D_0004;

    //        rst v0 r0 d0 v1 r1 d1 res rreg rs | r0 r1 st we wreg wdata busy  err
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0,   0, 0, 0, 0, 0, 0, 8'h00, 0);
    tbl[1]  = mk(0, 1, 3, A, 0, 0, 0, 0, 0, 3,   1, 0, 1, 0, 0, 0, 8'h08, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3,   0, 0, 1, 1, 3, A, 8'h08, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3,   0, 0, 0, 0, 3, A, 8'h00, 0);
    tbl[4]  = mk(1, 1, 1, B, 1, 2, C, 0, 0, 0,   0, 0, 0, 0, 3, A, 8'h00, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 4, 0,   0, 0, 0, 0, 0, 0, 8'h00, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 5, 0,   0, 0, 0, 0, 0, 0, 8'h10, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 6, 0,   0, 0, 0, 0, 0, 0, 8'h30, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0,   0, 0, 0, 0, 0, 0, 8'h70, 0);
    tbl[9]  = mk(0, 1, 4, B, 1, 5, C, 0, 0, 0,   1, 0, 0, 0, 0, 0, 8'hF0, 0);
    tbl[10] = mk(0, 1, 6, D, 1, 5, C, 0, 0, 0,   0, 1, 0, 1, 4, B, 8'hF0, 0);
    tbl[11] = mk(0, 1, 6, D, 1, 7, E, 1, 4, 0,   1, 0, 0, 1, 5, C, 8'hE0, 0);
    tbl[12] = mk(0, 1, 4, F, 1, 7, E, 0, 0, 0,   0, 1, 0, 1, 6, D, 8'hD0, 0);
    tbl[13] = mk(0, 1, 4, F, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 7, E, 8'h90, 0);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 4, F, 8'h10, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 4, F, 8'h00, 0);

    do_reset();

    for (int i = 0; i < 16; i++) begin
      reset_i       = tbl[i].rst;
      req0_valid_i  = tbl[i].v0;
      req0_reg_i    = tbl[i].r0;
      req0_data_i   = tbl[i].d0;
      req1_valid_i  = tbl[i].v1;
      req1_reg_i    = tbl[i].r1;
      req1_data_i   = tbl[i].d1;
      reserve_i     = tbl[i].res;
      reserve_reg_i = tbl[i].rreg;
      rs_sel_i      = tbl[i].rs;
      rt_sel_i      = '0;
      rd_sel_i      = '0;
      @(negedge clk);
      chk($sformatf("tbl%0d.ready0", i), 64'(req0_ready_o),   64'(tbl[i].e_r0));
      chk($sformatf("tbl%0d.ready1", i), 64'(req1_ready_o),   64'(tbl[i].e_r1));
      chk($sformatf("tbl%0d.stall", i),  64'(stall_o),        64'(tbl[i].e_stall));
      chk($sformatf("tbl%0d.we", i),     64'(write_enable_o), 64'(tbl[i].e_we));
      chk($sformatf("tbl%0d.wreg", i),   64'(write_reg_o),    64'(tbl[i].e_wreg));
      chk($sformatf("tbl%0d.wdata", i),  64'(write_data_o),   64'(tbl[i].e_wdata));
      chk($sformatf("tbl%0d.busy", i),   64'(busy_o),         64'(tbl[i].e_busy));
      chk($sformatf("tbl%0d.err", i),    64'(err_o),          64'(tbl[i].e_err));
      cyc();
    end
    reset_i = 1'b0;
    idle_inputs();

    // Reserve and commit to reg 2 in the same cycle: stays busy, no error
    do_reset();
    reserve_i = 1'b1; reserve_reg_i = 3'd2;
    cyc();
    reserve_i = 1'b0;
    req0_valid_i = 1'b1; req0_reg_i = 3'd2; req0_data_i = 34'h0_0000_0222;
    @(negedge clk);
    chk("same.ready0", 64'(req0_ready_o), 64'd1);
    cyc();
    req0_valid_i = 1'b0;
    reserve_i = 1'b1; reserve_reg_i = 3'd2;
    @(negedge clk);
    chk("same.we", 64'(write_enable_o), 64'd1);
    chk("same.wreg", 64'(write_reg_o), 64'd2);
    cyc();
    reserve_i = 1'b0;
    @(negedge clk);
    chk("same.busy", 64'(busy_o), 64'h04);
    chk("same.err", 64'(err_o), 64'd0);

    // Commit to a never-reserved register: sticky error
    do_reset();
    req1_valid_i = 1'b1; req1_reg_i = 3'd6; req1_data_i = 34'h3_0000_0006;
    @(negedge clk);
    chk("unres.ready1", 64'(req1_ready_o), 64'd1);
    cyc();
    req1_valid_i = 1'b0;
    @(negedge clk);
    chk("unres.err_before", 64'(err_o), 64'd0);
    cyc();
    @(negedge clk);
    chk("unres.err_set", 64'(err_o), 64'd1);
    repeat (10) cyc();
    @(negedge clk);
    chk("unres.err_sticky", 64'(err_o), 64'd1);
    chk("unres.busy", 64'(busy_o), 64'h00);

    // Double reserve of a busy register
    do_reset();
    reserve_i = 1'b1; reserve_reg_i = 3'd0;
    cyc();
    @(negedge clk);
    chk("dblres.err_before", 64'(err_o), 64'd0);
    cyc();
    reserve_i = 1'b0;
    @(negedge clk);
    chk("dblres.err", 64'(err_o), 64'd1);
    chk("dblres.stall", 64'(stall_o), 64'd1);

    // Reset in the cycle after an accept drops the write
    do_reset();
    reserve_i = 1'b1; reserve_reg_i = 3'd1;
    cyc();
    reserve_i = 1'b0;
    req0_valid_i = 1'b1; req0_reg_i = 3'd1; req0_data_i = 34'h1_1111_1111;
    @(negedge clk);
    chk("rstacc.ready0", 64'(req0_ready_o), 64'd1);
    cyc();
    req0_valid_i = 1'b0;
    reset_i = 1'b1;
    cyc();
    reset_i = 1'b0;
    @(negedge clk);
    chk("rstacc.we", 64'(write_enable_o), 64'd0);
    chk("rstacc.busy", 64'(busy_o), 64'h00);
    chk("rstacc.err", 64'(err_o), 64'd0);
    cyc();
    @(negedge clk);
    chk("rstacc.we_later", 64'(write_enable_o), 64'd0);

    // Randomized run against the behavioural model
    do_reset();
    m_ptr = 1'b0; m_we = 1'b0; m_wreg = '0; m_wdata = '0; m_busy = '0; m_err = 1'b0;
    for (int n = 0; n < 800; n++) begin
      reset_i = ($urandom_range(0, 99) < 2);
      if (!req0_valid_i && ($urandom_range(0, 99) < 60)) begin
        rnd = {$urandom, $urandom};
        req0_valid_i = 1'b1;
        req0_reg_i   = SW'($urandom_range(0, NR - 1));
        req0_data_i  = rnd[DW-1:0];
      end
      if (!req1_valid_i && ($urandom_range(0, 99) < 60)) begin
        rnd = {$urandom, $urandom};
        req1_valid_i = 1'b1;
        req1_reg_i   = SW'($urandom_range(0, NR - 1));
        req1_data_i  = rnd[DW-1:0];
      end
      reserve_i     = ($urandom_range(0, 99) < 35);
      reserve_reg_i = SW'($urandom_range(0, NR - 1));
      rs_sel_i      = SW'($urandom_range(0, NR - 1));
      rt_sel_i      = SW'($urandom_range(0, NR - 1));
      rd_sel_i      = SW'($urandom_range(0, NR - 1));

      win = -1;
      if (!reset_i) begin
        if (req0_valid_i && req1_valid_i) win = m_ptr ? 1 : 0;
        else if (req0_valid_i) win = 0;
        else if (req1_valid_i) win = 1;
      end

      @(negedge clk);
      chk("rnd.ready0", 64'(req0_ready_o),   64'(win == 0));
      chk("rnd.ready1", 64'(req1_ready_o),   64'(win == 1));
      chk("rnd.stall",  64'(stall_o),
          64'(m_busy[rs_sel_i] || m_busy[rt_sel_i] || m_busy[rd_sel_i]));
      chk("rnd.we",     64'(write_enable_o), 64'(m_we));
      chk("rnd.wreg",   64'(write_reg_o),    64'(m_wreg));
      chk("rnd.wdata",  64'(write_data_o),   64'(m_wdata));
      chk("rnd.busy",   64'(busy_o),         64'(m_busy));
      chk("rnd.err",    64'(err_o),          64'(m_err));

      @(posedge clk);
      if (reset_i) begin
        m_ptr = 1'b0; m_we = 1'b0; m_wreg = '0; m_wdata = '0; m_busy = '0; m_err = 1'b0;
      end else begin
        if (reserve_i && m_busy[reserve_reg_i] && !(m_we && (m_wreg == reserve_reg_i))) m_err = 1'b1;
        if (m_we && !m_busy[m_wreg]) m_err = 1'b1;
        nb = m_busy;
        if (m_we) nb[m_wreg] = 1'b0;
        if (reserve_i) nb[reserve_reg_i] = 1'b1;
        m_busy = nb;
        if (win == 0) begin
          m_we = 1'b1; m_wreg = req0_reg_i; m_wdata = req0_data_i; m_ptr = 1'b1;
        end else if (win == 1) begin
          m_we = 1'b1; m_wreg = req1_reg_i; m_wdata = req1_data_i; m_ptr = 1'b0;
        end else begin
          m_we = 1'b0;
        end
      end
      #1;
      if (win == 0) req0_valid_i = 1'b0;
      if (win == 1) req1_valid_i = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
